// File: rtl/load_align_unit.sv
// Load stage: takes a decoded byte-enable/load-type code, issues one word
// read to data memory, waits for the ack (or gives up after TIMEOUT cycles)
// and returns the selected, extended byte/halfword/word for writeback.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | ready for a request; req_ready follows ~flush
//   WAIT   | memory read outstanding, mem_req held, timeout counting
//   DONE   | result (or error) presented for one cycle on ld_valid
module load_align_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [6:0]  bel,
    input  logic [31:0] addr,
    input  logic [4:0]  rd_num,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ld_valid,
    output logic [31:0] ld_data,
    output logic [4:0]  ld_rd,
    output logic        ld_err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] T_LW  = 3'b000;
    localparam logic [2:0] T_LH  = 3'b001;
    localparam logic [2:0] T_LHU = 3'b010;
    localparam logic [2:0] T_LB  = 3'b011;
    localparam logic [2:0] T_LBU = 3'b100;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       typ_r;
    logic [3:0]       be_r;
    logic [4:0]       rd_r;
    logic             mem_req_r;
    logic [31:0]      mem_addr_r;
    logic [31:0]      data_r;
    logic             err_r;

    logic             accept;
    logic             bel_legal;
    logic [31:0]      ext_data;

    // Alignment is checked upstream; the low address bits select nothing here.
    logic [1:0]       unused_addr_lo;
    assign unused_addr_lo = addr[1:0];

    // Legal type/enable pairs: full word, aligned halfword, single byte.
    always_comb begin
        bel_legal = 1'b0;
        case (bel[6:4])
            T_LW:         bel_legal = (bel[3:0] == 4'b1111);
            T_LH, T_LHU:  bel_legal = (bel[3:0] == 4'b0011) || (bel[3:0] == 4'b1100);
            T_LB, T_LBU:  bel_legal = (bel[3:0] == 4'b0001) || (bel[3:0] == 4'b0010) ||
                                      (bel[3:0] == 4'b0100) || (bel[3:0] == 4'b1000);
            default:      bel_legal = 1'b0;
        endcase
    end

    // Lane selection and sign/zero extension of the returned memory word.
    always_comb begin
        logic [15:0] half;
        logic [7:0]  byte_sel;
        half     = be_r[2] ? mem_rdata[31:16] : mem_rdata[15:0];
        byte_sel = mem_rdata[7:0];
        case (be_r)
            4'b0010: byte_sel = mem_rdata[15:8];
            4'b0100: byte_sel = mem_rdata[23:16];
            4'b1000: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        ext_data = mem_rdata;
        case (typ_r)
            T_LH:    ext_data = {{16{half[15]}}, half};
            T_LHU:   ext_data = {16'h0000, half};
            T_LB:    ext_data = {{24{byte_sel[7]}}, byte_sel};
            T_LBU:   ext_data = {24'h000000, byte_sel};
            default: ext_data = mem_rdata;
        endcase
    end

    assign accept = (state == S_IDLE) && req_valid && !flush;

    // Sequencer: accept, wait for ack or timeout, present the result once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            typ_r      <= 3'b000;
            be_r       <= 4'b0000;
            rd_r       <= 5'd0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= 32'h0;
            data_r     <= 32'h0;
            err_r      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        typ_r <= bel[6:4];
                        be_r  <= bel[3:0];
                        rd_r  <= rd_num;
                        cnt   <= '0;
                        if (bel_legal) begin
                            state      <= S_WAIT;
                            mem_req_r  <= 1'b1;
                            mem_addr_r <= {addr[31:2], 2'b00};
                        end else begin
                            // Illegal code: report immediately, never touch memory.
                            state  <= S_DONE;
                            err_r  <= 1'b1;
                            data_r <= 32'h0;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        state     <= S_IDLE;
                        mem_req_r <= 1'b0;
                    end else if (mem_ack) begin
                        // Ack is checked before the terminal count so it wins a tie.
                        state     <= S_DONE;
                        mem_req_r <= 1'b0;
                        data_r    <= ext_data;
                        err_r     <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= S_DONE;
                        mem_req_r <= 1'b0;
                        data_r    <= 32'h0;
                        err_r     <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                end
                default: begin
                    state     <= S_IDLE;
                    mem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Handshake and result outputs; flush masks the DONE pulse and new accepts.
    always_comb begin
        req_ready = (state == S_IDLE) && !flush;
        ld_valid  = (state == S_DONE) && !flush;
        ld_err    = ld_valid && err_r;
        ld_data   = data_r;
        ld_rd     = rd_r;
        mem_req   = mem_req_r;
        mem_addr  = mem_addr_r;
    end

endmodule

// File: tb/tb_load_align_unit.sv
// Self-checking bench for load_align_unit: directed corner cases plus a
// randomized load stream; results checked by a queue-based scoreboard.
module tb_load_align_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [6:0]  bel = 7'd0;
    logic [31:0] addr = 32'd0;
    logic [4:0]  rd_num = 5'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic [4:0]  ld_rd;
    logic        ld_err;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        err;
    } exp_t;

    exp_t exp_q[$];

    load_align_unit #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .bel(bel), .addr(addr), .rd_num(rd_num),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_rd(ld_rd), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: legality and extraction from the load rules.
    function automatic logic model_legal(input logic [6:0] b);
        logic [3:0] be;
        be = b[3:0];
        case (b[6:4])
            3'd0:       return be == 4'hF;
            3'd1, 3'd2: return (be == 4'h3) || (be == 4'hC);
            3'd3, 3'd4: return (be != 4'h0) && ((be & (be - 4'h1)) == 4'h0);
            default:    return 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] model_data(input logic [6:0] b, input logic [31:0] w);
        int lane;
        logic [31:0] sh;
        lane = 0;
        for (int i = 3; i >= 0; i--) if (b[i]) lane = i;
        sh = w >> (8 * lane);
        case (b[6:4])
            3'd1:    return {{16{sh[15]}}, sh[15:0]};
            3'd2:    return {16'h0, sh[15:0]};
            3'd3:    return {{24{sh[7]}}, sh[7:0]};
            3'd4:    return {24'h0, sh[7:0]};
            default: return w;
        endcase
    endfunction

    // Monitor: every ld_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && ld_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_ld_valid data=%h rd=%0d err=%b t=%0t",
                         ld_data, ld_rd, ld_err, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ld_data", ld_data, e.data);
                check("ld_rd", {27'd0, ld_rd}, {27'd0, e.rd});
                check("ld_err", {31'd0, ld_err}, {31'd0, e.err});
            end
        end
    end

    // Present a request and hold it until accepted; returns #1 into cycle N+1.
    task automatic issue(input logic [6:0] b, input logic [31:0] a, input logic [4:0] rd);
        int waited;
        @(posedge clk); #1;
        req_valid = 1'b1; bel = b; addr = a; rd_num = rd;
        waited = 0;
        @(negedge clk);
        while (!req_ready) begin
            waited++;
            if (waited > 50) begin
                $display("FAIL req_ready_timeout actual=0 expected=1 t=%0t", $time);
                $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
                $fatal(1, "req_ready never asserted");
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        bel = 7'($urandom); addr = $urandom; rd_num = 5'($urandom);
    endtask

    // One load: d = cycles of mem_req before the ack (d >= TIMEOUT means no ack).
    task automatic do_load(input logic [6:0] b, input logic [31:0] a, input logic [4:0] rd,
                           input int d, input logic [31:0] w);
        exp_t e;
        logic legal;
        legal = model_legal(b);
        e.rd = rd;
        if (!legal || d >= TIMEOUT) begin
            e.data = 32'h0; e.err = 1'b1;
        end else begin
            e.data = model_data(b, w); e.err = 1'b0;
        end
        exp_q.push_back(e);
        issue(b, a, rd);
        if (!legal) begin
            check("illegal_no_mem_req", {31'd0, mem_req}, 32'd0);
            @(negedge clk);
            check("illegal_valid_err", {30'd0, ld_valid, ld_err}, 32'd3);
            @(posedge clk); #1;
            check("illegal_no_mem_req_late", {31'd0, mem_req}, 32'd0);
        end else begin
            check("mem_req_start", {31'd0, mem_req}, 32'd1);
            check("mem_addr", mem_addr, {a[31:2], 2'b00});
            if (d < TIMEOUT) begin
                repeat (d) @(posedge clk);
                #1 mem_ack = 1'b1; mem_rdata = w;
                @(posedge clk); #1;
                mem_ack = 1'b0; mem_rdata = $urandom;
                check("mem_req_drop", {31'd0, mem_req}, 32'd0);
                @(negedge clk);
                check("ack_to_valid", {31'd0, ld_valid}, 32'd1);
            end else begin
                repeat (TIMEOUT) @(posedge clk);
                #1;
                check("timeout_mem_req_drop", {31'd0, mem_req}, 32'd0);
                mem_ack = 1'b1; mem_rdata = $urandom;
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished t=%0t", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] legal_tbl [12];
        int hi;
        legal_tbl = '{7'b0001111, 7'b0010011, 7'b0011100, 7'b0100011, 7'b0101100,
                      7'b0110001, 7'b0110010, 7'b0110100, 7'b0111000,
                      7'b1000001, 7'b1000100, 7'b1001000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req_ready", {31'd0, req_ready}, 32'd1);
        check("reset_mem_req", {31'd0, mem_req}, 32'd0);
        check("reset_mem_addr", mem_addr, 32'd0);
        check("reset_ld_valid", {31'd0, ld_valid}, 32'd0);
        check("reset_ld_data", ld_data, 32'd0);

        do_load(7'b0001111, 32'h100, 5'd3, 2, 32'h89ABCDEF);
        do_load(7'b0110100, 32'h206, 5'd4, 0, 32'h12F45678);
        do_load(7'b1000100, 32'h206, 5'd5, 1, 32'h12F45678);
        do_load(7'b0011100, 32'h302, 5'd6, 3, 32'h8001FFFF);
        do_load(7'b0101100, 32'h302, 5'd7, 0, 32'h8001FFFF);
        do_load(7'b0010110, 32'h400, 5'd8, 0, 32'h0);
        do_load(7'b0001111, 32'h504, 5'd9, TIMEOUT - 1, 32'hCAFEF00D);

        // Timeout: mem_req must stay up for exactly TIMEOUT cycles, stray ack ignored.
        exp_q.push_back('{data: 32'h0, rd: 5'd10, err: 1'b1});
        issue(7'b0001111, 32'h600, 5'd10);
        hi = 0;
        repeat (TIMEOUT + 3) begin
            if (mem_req) hi++;
            @(posedge clk); #1;
        end
        check("timeout_mem_req_cycles", 32'(hi), 32'(TIMEOUT));
        mem_ack = 1'b1;
        repeat (2) @(posedge clk);
        #1 mem_ack = 1'b0;
        check("stray_ack_no_mem_req", {31'd0, mem_req}, 32'd0);

        // Flush coincident with ack in WAIT: no result, ready again afterwards.
        issue(7'b0001111, 32'h700, 5'd11);
        @(posedge clk); #1;
        flush = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h11111111;
        @(posedge clk); #1;
        flush = 1'b0; mem_ack = 1'b0;
        check("flush_mem_req_drop", {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("flush_req_ready_after", {31'd0, req_ready}, 32'd1);

        // Flush during DONE suppresses the pulse.
        issue(7'b0001111, 32'h800, 5'd12);
        mem_ack = 1'b1; mem_rdata = 32'h22222222;
        @(posedge clk); #1;
        mem_ack = 1'b0; flush = 1'b1;
        @(negedge clk);
        check("flush_done_no_valid", {31'd0, ld_valid}, 32'd0);
        @(posedge clk); #1 flush = 1'b0;

        // Flush in IDLE blocks acceptance.
        @(posedge clk); #1;
        req_valid = 1'b1; bel = 7'b0001111; addr = 32'h900; flush = 1'b1;
        @(negedge clk);
        check("flush_idle_not_ready", {31'd0, req_ready}, 32'd0);
        @(posedge clk); #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flush_idle_no_mem_req", {31'd0, mem_req}, 32'd0);

        // Reset mid-WAIT drops the access and clears every output.
        issue(7'b0001111, 32'hA00, 5'd13);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_ld_valid", {31'd0, ld_valid}, 32'd0);
        check("rst_ld_data", ld_data, 32'd0);
        check("rst_ld_rd", {27'd0, ld_rd}, 32'd0);
        check("rst_ld_err", {31'd0, ld_err}, 32'd0);
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        do_load(7'b0001111, 32'hB00, 5'd14, 1, 32'h5A5AA5A5);

        // Randomized stream.
        for (int n = 0; n < 60; n++) begin
            logic [6:0] b;
            int d;
            if ($urandom_range(0, 3) == 0) b = 7'($urandom);
            else b = legal_tbl[$urandom_range(0, 11)];
            d = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                            : $urandom_range(0, 6);
            do_load(b, $urandom, 5'($urandom), d, $urandom);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
